// File: rtl/stream_demux4.sv
// Four-way stream demultiplexer: each beat is routed by in_sel into one of four
// independent 2-entry FIFOs, so a stalled consumer only blocks beats addressed to it.
module stream_demux4 #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_BITS-1:0] in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data0,
  output logic [WIDTH-1:0]    out_data1,
  output logic [WIDTH-1:0]    out_data2,
  output logic [WIDTH-1:0]    out_data3,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1,
  output logic [CNT_W-1:0]    cnt2,
  output logic [CNT_W-1:0]    cnt3
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_st_e;

  logic             w_full  [4];
  logic             w_valid [4];
  logic [WIDTH-1:0] w_head  [4];
  logic [CNT_W-1:0] w_cnt   [4];
  logic             w_accept;

  // Ready depends only on the addressed FIFO's occupancy, never on out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = ~w_full[in_sel];
    end else begin
      in_ready = 1'b0;
    end
    w_accept = in_valid & in_ready;
  end

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    fifo_st_e         r_st;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push = w_accept & (in_sel == SEL_BITS'(g));
    assign w_pop  = r_valid & out_ready[g];

    // Per-output FIFO state machine; entry 0 (r_head) is always the oldest beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_st    <= ST_EMPTY;
        r_valid <= 1'b0;
        r_head  <= '0;
        r_tail  <= '0;
        r_cnt   <= '0;
      end else begin
        if (w_pop) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        case (r_st)
          ST_EMPTY: begin
            if (w_push) begin
              r_head  <= in_data;
              r_st    <= ST_ONE;
              r_valid <= 1'b1;
            end
          end
          ST_ONE: begin
            case ({w_push, w_pop})
              2'b10: begin
                r_tail <= in_data;
                r_st   <= ST_FULL;
              end
              2'b01: begin
                r_st    <= ST_EMPTY;
                r_valid <= 1'b0;
              end
              2'b11: r_head <= in_data;
              default: ;
            endcase
          end
          ST_FULL: begin
            // No push can arrive here: in_ready is low for a full FIFO.
            if (w_pop) begin
              r_head <= r_tail;
              r_st   <= ST_ONE;
            end
          end
          default: begin
            r_st    <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        endcase
      end
    end

    assign w_full[g]  = (r_st == ST_FULL);
    assign w_valid[g] = r_valid;
    assign w_head[g]  = r_head;
    assign w_cnt[g]   = r_cnt;
  end

  assign out_valid = {w_valid[3], w_valid[2], w_valid[1], w_valid[0]};
  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];
  assign cnt0      = w_cnt[0];
  assign cnt1      = w_cnt[1];
  assign cnt2      = w_cnt[2];
  assign cnt3      = w_cnt[3];

endmodule

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: hand-derived vector table, directed corner sequences,
// and constrained-random traffic checked against a queue-based reference model.
module tb_stream_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q [4][$];
  logic [7:0] ecnt [4];

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [7:0] e_hd;
  } vec_t;

  vec_t tbl [20];

  stream_demux4 #(.WIDTH(8), .SEL_BITS(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] get_data(int i);
    case (i)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [7:0] get_cnt(int i);
    case (i)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      ecnt[i] = 8'd0;
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk("m_valid", i, 32'(out_valid[i]), 32'(q[i].size() != 0));
      if (q[i].size() != 0) chk("m_data", i, 32'(get_data(i)), 32'(q[i][0]));
      chk("m_cnt", i, 32'(get_cnt(i)), 32'(ecnt[i]));
    end
  endtask

  // One clock cycle: drive, check ready against the model, clock, advance the model, check.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d,
                     input logic [3:0] r, output logic ir_seen);
    logic exp_ir;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    ir_seen = in_ready;
    exp_ir  = (q[s].size() != 2);
    chk("m_in_ready", int'(s), 32'(in_ready), 32'(exp_ir));
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() != 0 && r[i]) begin
        void'(q[i].pop_front());
        ecnt[i] = ecnt[i] + 8'd1;
      end
    end
    if (v && exp_ir) q[s].push_back(d);
    #1;
    check_model();
  endtask

  initial begin
    logic ir;
    logic       pv;
    logic [1:0] ps;
    logic [7:0] pd;

    // routing, then backpressure on output 1, push+pop in ONE, head-of-line on output 3
    tbl[0]  = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0001, 8'h11};
    tbl[1]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 8'h22};
    tbl[2]  = '{1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'b0100, 8'h33};
    tbl[3]  = '{1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'b1000, 8'h44};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00};
    tbl[5]  = '{1'b1, 2'd1, 8'hA0, 4'hD, 1'b1, 4'b0010, 8'hA0};
    tbl[6]  = '{1'b1, 2'd1, 8'hA1, 4'hD, 1'b1, 4'b0010, 8'hA0};
    tbl[7]  = '{1'b1, 2'd1, 8'hA2, 4'hD, 1'b0, 4'b0010, 8'hA0};
    tbl[8]  = '{1'b1, 2'd1, 8'hA2, 4'hF, 1'b0, 4'b0010, 8'hA1};
    tbl[9]  = '{1'b1, 2'd1, 8'hA2, 4'hF, 1'b1, 4'b0010, 8'hA2};
    tbl[10] = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00};
    tbl[11] = '{1'b1, 2'd0, 8'h55, 4'h0, 1'b1, 4'b0001, 8'h55};
    tbl[12] = '{1'b1, 2'd0, 8'h66, 4'h1, 1'b1, 4'b0001, 8'h66};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 4'b0000, 8'h00};
    tbl[14] = '{1'b1, 2'd3, 8'hB0, 4'h0, 1'b1, 4'b1000, 8'hB0};
    tbl[15] = '{1'b1, 2'd3, 8'hB1, 4'h0, 1'b1, 4'b1000, 8'hB0};
    tbl[16] = '{1'b1, 2'd0, 8'hC0, 4'h0, 1'b1, 4'b1001, 8'hC0};
    tbl[17] = '{1'b1, 2'd3, 8'hD0, 4'h0, 1'b0, 4'b1001, 8'hB0};
    tbl[18] = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b0, 4'b1000, 8'hB1};
    tbl[19] = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b1, 4'b0000, 8'h00};

    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_in_ready", 0, 32'(in_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_data", i, 32'(get_data(i)), 32'h0);
      chk("rst_cnt", i, 32'(get_cnt(i)), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 0, 32'(in_ready), 32'h1);

    for (int k = 0; k < 20; k++) begin
      cyc(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].rdy, ir);
      chk("tbl_in_ready", k, 32'(ir), 32'(tbl[k].e_ir));
      chk("tbl_out_valid", k, 32'(out_valid), 32'(tbl[k].e_ov));
      if (tbl[k].e_ov[tbl[k].sel]) chk("tbl_head", k, 32'(get_data(int'(tbl[k].sel))), 32'(tbl[k].e_hd));
    end
    chk("tbl_cnt0", 0, 32'(cnt0), 32'd4);
    chk("tbl_cnt1", 1, 32'(cnt1), 32'd4);
    chk("tbl_cnt2", 2, 32'(cnt2), 32'd1);
    chk("tbl_cnt3", 3, 32'(cnt3), 32'd3);

    // Counter wrap on output 2 at full rate: 255 more deliveries take cnt2 from 1 to 0.
    for (int k = 0; k < 255; k++) begin
      cyc(1'b1, 2'd2, 8'(k), 4'b0100, ir);
      if (!ir) chk("wrap_stream_ready", k, 32'(ir), 32'h1);
    end
    chk("wrap_cnt2_255", 2, 32'(cnt2), 32'd255);
    cyc(1'b0, 2'd2, 8'h00, 4'b0100, ir);
    chk("wrap_cnt2_0", 2, 32'(cnt2), 32'd0);
    chk("wrap_cnt0", 0, 32'(cnt0), 32'd4);
    chk("wrap_cnt1", 1, 32'(cnt1), 32'd4);
    chk("wrap_cnt3", 3, 32'(cnt3), 32'd3);

    // Random traffic; a refused beat is held stable until accepted.
    pv = 1'b0; ps = 2'd0; pd = 8'h00; ir = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!(pv && !ir)) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 2'($urandom_range(0, 3));
        pd = 8'($urandom);
      end
      cyc(pv, ps, pd, 4'($urandom), ir);
    end

    // Reset mid-traffic with FIFO 2 holding two beats.
    repeat (3) cyc(1'b0, 2'd0, 8'h00, 4'hF, ir);
    cyc(1'b1, 2'd2, 8'h5A, 4'h0, ir);
    cyc(1'b1, 2'd2, 8'hA5, 4'h0, ir);
    chk("pre_rst_full", 2, 32'(in_ready), 32'h0);
    in_valid = 1'b1; in_sel = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("mid_rst_cnt2", 2, 32'(cnt2), 32'h0);
    chk("mid_rst_data2", 2, 32'(out_data2), 32'h0);
    chk("mid_rst_in_ready", 0, 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_release_in_ready", 0, 32'(in_ready), 32'h1);
    cyc(1'b1, 2'd2, 8'h77, 4'h0, ir);
    cyc(1'b0, 2'd2, 8'h00, 4'hF, ir);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
